fetch_sequencer: RTL

Controller for the fetch-stage PC register and the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage RV64 pipeline. It generates pc_write/pc_src and the per-stage write/flush controls. It detects load-use hazards, applies branch redirects resolved in MEM, drains the pipeline when the PC reaches the program limit, then halts. It also keeps cycle, stall and flush performance counters.

---
 rtl/fetch_sequencer_pkg.sv | 14 +
 rtl/fetch_sequencer_if.sv | 36 +++
 rtl/fetch_sequencer_sat_counter.sv | 19 +
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch-stage sequencer of the 5-stage RV64 pipeline.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [63:0] PC_LIMIT_DEF = 64'h200;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Pipeline-facing signal bundle of the fetch sequencer: hazard/redirect inputs, control and status outputs.
interface fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [63:0]      pc_current;
    logic             branch_taken;
    logic [63:0]      pc_branch;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd;
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;

    logic             pc_write;
    logic             pc_src;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output pc_current, branch_taken, pc_branch, id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
        input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
        input  halted, fault, cycle_count, stall_count, flush_count
    );

    modport slave (
        input  pc_current, branch_taken, pc_branch, id_ex_mem_read, id_ex_rd, if_id_rs1, if_id_rs2,
        output pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
        output halted, fault, cycle_count, stall_count, flush_count
    );
endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter used for the sequencer performance statistics; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: PC/pipeline-register control, load-use stalls, MEM-stage redirects,
// end-of-program drain and halt, plus cycle/stall/flush statistics.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [63:0] PC_LIMIT     = PC_LIMIT_DEF,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    fetch_sequencer_if.slave bus
);

    localparam int          DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

    state_t          state, state_n;
    logic [DW-1:0]   drain_cnt, drain_cnt_n;
    logic            halted_r, fault_r;
    logic            set_fault, stall_inc, flush_inc;

    logic            pc_write, pc_src, if_id_write;
    logic            if_id_flush, id_ex_flush, ex_mem_flush;

    logic            lu, bf, br, at_limit, tgt_ok;

    assign lu       = bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
                      ((bus.id_ex_rd == bus.if_id_rs1) || (bus.id_ex_rd == bus.if_id_rs2));
    assign bf       = bus.branch_taken && (bus.pc_branch[1:0] != 2'b00);
    assign br       = bus.branch_taken && !bf;
    assign at_limit = bus.pc_current >= (PC_LIMIT - 64'd4);
    assign tgt_ok   = bus.pc_branch < PC_LIMIT;

    always_comb begin
        pc_write     = 1'b1;
        pc_src       = 1'b0;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        state_n      = state;
        drain_cnt_n  = drain_cnt;
        set_fault    = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        case (state)
            BOOT: begin
                pc_write     = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                state_n      = RUN;
            end
            RUN: begin
                // A redirect squashes the younger load-use pair, so it wins over the stall.
                if (bf) begin
                    pc_write     = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    set_fault    = 1'b1;
                    state_n      = HALT;
                end else if (br) begin
                    pc_src       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    flush_inc    = 1'b1;
                end else if (lu) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_flush  = 1'b1;
                    stall_inc    = 1'b1;
                end else if (at_limit) begin
                    pc_write     = 1'b0;
                    if_id_flush  = 1'b1;
                    state_n      = DRAIN;
                    drain_cnt_n  = DRAIN_INIT;
                end
            end
            DRAIN: begin
                pc_write    = 1'b0;
                if_id_flush = 1'b1;
                if (bf) begin
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    set_fault    = 1'b1;
                    state_n      = HALT;
                end else if (br && tgt_ok) begin
                    pc_write     = 1'b1;
                    pc_src       = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    flush_inc    = 1'b1;
                    state_n      = RUN;
                end else if (br) begin
                    // Redirect past the end of the program: clean completion, not a fault.
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    state_n      = HALT;
                end else if (lu) begin
                    if_id_write  = 1'b0;
                    id_ex_flush  = 1'b1;
                    stall_inc    = 1'b1;
                end else if (drain_cnt == '0) begin
                    state_n      = HALT;
                end else begin
                    drain_cnt_n  = drain_cnt - DW'(1);
                end
            end
            HALT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BOOT;
            drain_cnt <= '0;
            halted_r  <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
            if (state_n == HALT) halted_r <= 1'b1;
            if (set_fault)       fault_r  <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state != HALT),
        .count (bus.cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (bus.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (bus.flush_count)
    );

    assign bus.pc_write     = pc_write;
    assign bus.pc_src       = pc_src;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.halted       = halted_r;
    assign bus.fault        = fault_r;

endmodule
